// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the TinyRV1 fetch unit.
package fetch_pkg;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_t;
    localparam logic [31:0] PC_INCR      = 32'd4;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/fetch_inst_buf.sv
// fetch_inst_buf: one-entry {inst, pc} holding register; clear wins over load.
module fetch_inst_buf
    import fetch_pkg::*;
#(
    parameter int p_addr_nbits = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    clear,
    input  logic [31:0]             data,
    input  logic [p_addr_nbits-1:0] pc,
    output logic [31:0]             inst,
    output logic [p_addr_nbits-1:0] inst_pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst    <= '0;
            inst_pc <= '0;
        end else if (clear) begin
            inst    <= '0;
            inst_pc <= '0;
        end else if (load) begin
            inst    <= data;
            inst_pc <= pc;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: TinyRV1 fetch front end with one outstanding imem request and a one-entry buffer.
// Define FETCH_PERF_CNT_EN to add perf_fetch_cnt / perf_drop_cnt counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      p_addr_nbits = 32,
    parameter logic [p_addr_nbits-1:0] p_reset_addr = p_addr_nbits'(RESET_VECTOR)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_val,
    input  logic [p_addr_nbits-1:0] redirect_target,
    output logic                    imemreq_val,
    input  logic                    imemreq_rdy,
    output logic [p_addr_nbits-1:0] imemreq_addr,
    input  logic                    imemresp_val,
    input  logic [31:0]             imemresp_data,
    output logic                    inst_val,
    input  logic                    inst_rdy,
    output logic [31:0]             inst,
`ifdef FETCH_PERF_CNT_EN
    output logic [p_addr_nbits-1:0] inst_pc,
    output logic [31:0]             perf_fetch_cnt,
    output logic [31:0]             perf_drop_cnt
`else
    output logic [p_addr_nbits-1:0] inst_pc
`endif
);
    fetch_state_t            state;
    logic [p_addr_nbits-1:0] pc;
    logic                    drop;
    logic                    resp;
    logic                    load;
    logic                    clear;

    assign imemreq_val  = state == S_REQ && !redirect_val && !rst;
    assign imemreq_addr = pc;
    assign inst_val     = state == S_HOLD;
    assign resp         = state == S_WAIT && imemresp_val;
    assign load         = resp && !drop && !redirect_val;
    assign clear        = state == S_HOLD && redirect_val;

    fetch_inst_buf #(.p_addr_nbits(p_addr_nbits)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .clear   (clear),
        .data    (imemresp_data),
        .pc      (pc),
        .inst    (inst),
        .inst_pc (inst_pc)
    );

    // A redirect in S_WAIT without a response leaves one stale response in flight to drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= p_reset_addr;
            state <= S_REQ;
            drop  <= 1'b0;
        end else if (redirect_val) begin
            pc    <= redirect_target;
            drop  <= state == S_WAIT && !imemresp_val;
            state <= (state == S_WAIT && !imemresp_val) ? S_WAIT : S_REQ;
        end else begin
            case (state)
                S_REQ:  if (imemreq_rdy) state <= S_WAIT;
                S_WAIT: if (imemresp_val) begin
                    drop  <= 1'b0;
                    state <= drop ? S_REQ : S_HOLD;
                    if (!drop) pc <= pc + p_addr_nbits'(PC_INCR);
                end
                S_HOLD: if (inst_rdy) state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(inst_val && inst_rdy && !redirect_val);
            perf_drop_cnt  <= perf_drop_cnt + 32'((resp && (drop || redirect_val)) || clear);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a latency-programmable memory model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_val;
    logic [31:0] redirect_target;
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic [31:0] imemresp_data;
    logic        inst_val;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int errs = 0;
    int checks = 0;
    int pops = 0;
    int lat = 1;
    int pend_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [63:0] q[$];
    logic [31:0] reqs[$];
    logic        s_rv, s_iv;
    logic [31:0] s_ra, s_inst, s_pc;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_val    (redirect_val),
        .redirect_target (redirect_target),
        .imemreq_val     (imemreq_val),
        .imemreq_rdy     (imemreq_rdy),
        .imemreq_addr    (imemreq_addr),
        .imemresp_val    (imemresp_val),
        .imemresp_data   (imemresp_data),
        .inst_val        (inst_val),
        .inst_rdy        (inst_rdy),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] md(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample settled outputs, score transfers, model memory, advance.
    task automatic cyc();
        logic [63:0] e;
        #1;
        s_rv = imemreq_val;
        s_ra = imemreq_addr;
        s_iv = inst_val;
        s_inst = inst;
        s_pc = inst_pc;
        if (s_iv) chk("val_has_entry", 64'(q.size() != 0), 64'd1);
        if (s_iv && inst_rdy && !redirect_val && q.size() != 0) begin
            e = q.pop_front();
            pops++;
            chk("inst_pc", 64'(s_pc), 64'(e[63:32]));
            chk("inst", 64'(s_inst), 64'(e[31:0]));
        end
        if (redirect_val) q.delete();
        if (s_rv && imemreq_rdy) begin
            q.push_back({s_ra, md(s_ra)});
            reqs.push_back(s_ra);
            pend = 1'b1;
            pend_cnt = lat;
            pend_addr = s_ra;
        end
        @(posedge clk);
        #1;
        redirect_val = 1'b0;
        imemresp_val = 1'b0;
        imemresp_data = 32'hBAD0_0BAD;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend = 1'b0;
                imemresp_val = 1'b1;
                imemresp_data = md(pend_addr);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect_val = 1'b0;
        redirect_target = '0;
        imemreq_rdy = 1'b1;
        imemresp_val = 1'b0;
        imemresp_data = '0;
        inst_rdy = 1'b1;
        #3;
        chk("rst_req_val", 64'(imemreq_val), 64'd0);
        chk("rst_inst_val", 64'(inst_val), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("rst_addr", 64'(imemreq_addr), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Streaming fetch with 1-cycle memory and ready decode
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("t1_inst_val", 64'(s_iv), 64'(i % 3 == 2));
        end
        chk("t1_nreq", 64'(reqs.size()), 64'd3);
        chk("t1_req0", 64'(reqs[0]), 64'h0);
        chk("t1_req1", 64'(reqs[1]), 64'h4);
        chk("t1_req2", 64'(reqs[2]), 64'h8);
        chk("t1_pops", 64'(pops), 64'd3);
        // Memory not ready: request held
        imemreq_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_req_val", 64'(s_rv), 64'd1);
            chk("t2_addr", 64'(s_ra), 64'hC);
        end
        chk("t2_nreq", 64'(reqs.size()), 64'd3);
        imemreq_rdy = 1'b1;
        // Decode stalled: buffer stable, no new request
        inst_rdy = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t3_inst_val", 64'(s_iv), 64'd1);
            chk("t3_inst_pc", 64'(s_pc), 64'hC);
            chk("t3_inst", 64'(s_inst), 64'(md(32'hC)));
            chk("t3_req_val", 64'(s_rv), 64'd0);
        end
        inst_rdy = 1'b1;
        cyc();
        chk("t3_pops", 64'(pops), 64'd4);
        lat = 2;
        cyc();
        chk("t3_next_addr", 64'(s_ra), 64'h10);
        chk("t3_next_val", 64'(s_rv), 64'd1);
        // Redirect in S_WAIT before the response arrives
        redirect_val = 1'b1;
        redirect_target = 32'h100;
        cyc();
        chk("t4_redir_noreq", 64'(s_rv), 64'd0);
        cyc();
        chk("t4_dropped", 64'(s_iv), 64'd0);
        lat = 1;
        cyc();
        chk("t4_req_val", 64'(s_rv), 64'd1);
        chk("t4_req_addr", 64'(s_ra), 64'h100);
        cyc();
        cyc();
        chk("t4_inst_val", 64'(s_iv), 64'd1);
        chk("t4_pops", 64'(pops), 64'd5);
        // Redirect in the same cycle as the response
        cyc();
        redirect_val = 1'b1;
        redirect_target = 32'h200;
        cyc();
        cyc();
        chk("t5_req_val", 64'(s_rv), 64'd1);
        chk("t5_req_addr", 64'(s_ra), 64'h200);
        cyc();
        cyc();
        chk("t5_inst_val", 64'(s_iv), 64'd1);
        chk("t5_pops", 64'(pops), 64'd6);
        // Redirect while holding: no transfer
        cyc();
        cyc();
        redirect_val = 1'b1;
        redirect_target = 32'h300;
        cyc();
        chk("t5b_held", 64'(s_iv), 64'd1);
        chk("t5b_pops", 64'(pops), 64'd6);
        cyc();
        chk("t5b_req_addr", 64'(s_ra), 64'h300);
        cyc();
        cyc();
        chk("t5b_pops2", 64'(pops), 64'd7);
        // PC wrap
        redirect_val = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cyc();
        chk("t6_redir_noreq", 64'(s_rv), 64'd0);
        cyc();
        chk("t6_req_top", 64'(s_ra), 64'hFFFF_FFFC);
        cyc();
        cyc();
        chk("t6_pops", 64'(pops), 64'd8);
        cyc();
        chk("t6_wrap_addr", 64'(s_ra), 64'h0);
        chk("t6_wrap_val", 64'(s_rv), 64'd1);
        cyc();
        cyc();
        chk("t6_pops2", 64'(pops), 64'd9);
        lat = 3;
        cyc();
        chk("t7_req_addr", 64'(s_ra), 64'h4);
        // Asynchronous reset in S_WAIT
        rst = 1'b1;
        #1;
        chk("t7_rst_req_val", 64'(imemreq_val), 64'd0);
        chk("t7_rst_inst_val", 64'(inst_val), 64'd0);
        chk("t7_rst_inst", 64'(inst), 64'd0);
        chk("t7_rst_addr", 64'(imemreq_addr), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend = 1'b0;
        q.delete();
        // Stray response while in S_REQ is ignored
        imemreq_rdy = 1'b0;
        imemresp_val = 1'b1;
        imemresp_data = 32'h0000_1234;
        cyc();
        chk("t8_req_val", 64'(s_rv), 64'd1);
        chk("t8_req_addr", 64'(s_ra), 64'h0);
        imemreq_rdy = 1'b1;
        lat = 1;
        cyc();
        chk("t8_no_inst", 64'(s_iv), 64'd0);
        chk("t8_fire_addr", 64'(s_ra), 64'h0);
        cyc();
        cyc();
        chk("t8_inst_val", 64'(s_iv), 64'd1);
        chk("t8_pops", 64'(pops), 64'd10);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
